reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised 2-read/1-write register file for the MIPS pipeline, generalised in data width and depth.
- Adds four behaviours: optional hardwired-zero register 0, optional write-to-read bypass, asynchronous reset of all entries, and a per-register pending-write scoreboard with a pending-count.
- Sits in decode. The read ports feed the operand latches. BUSY outputs drive the hazard/stall unit; SET_EN is driven by issue of long-latency writers (loads); WE3 is driven by writeback.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, width of the address ports.
- NUM_REGS, 32, number of implemented registers. Must satisfy 2 <= NUM_REGS <= 2**ADDR_W.
- ZERO_REG, 1, when 1, register 0 always reads 0 and is never written or marked busy.
- BYPASS, 1, when 1, a same-cycle write is forwarded combinationally to the read ports and to BUSY.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- WE3  in  1  write enable (writeback).
- A1  in  ADDR_W  read address, port 1.
- A2  in  ADDR_W  read address, port 2.
- A3  in  ADDR_W  write address.
- WD3  in  DATA_W  write data.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- SET_EN  in  1  mark register SET_A as pending.
- SET_A  in  ADDR_W  register to mark pending.
- CLR_ALL  in  1  flush: clear all pending bits.
- BUSY1  out  1  pending status of A1.
- BUSY2  out  1  pending status of A2.
- PEND_CNT  out  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset: RST high immediately clears all registers, all pending bits and PEND_CNT to 0, with no dependence on CLK. RD1/RD2 then read 0, BUSY1/BUSY2 read 0, PEND_CNT reads 0. Deassertion is taken synchronously by the next CLK edge. RST asserted mid-operation discards any write or set arriving on that edge.
- Write: on CLK rising edge, if WE3 is high and A3 is valid, then rf[A3] <= WD3.
  - A3 is invalid if A3 >= NUM_REGS, or if ZERO_REG=1 and A3==0.
  - An invalid write is ignored.
- Read is combinational.
  - An address >= NUM_REGS reads 0.
  - With ZERO_REG=1, address 0 reads 0.
  - With BYPASS=1, if WE3 is high, A3 is valid and A3==A1, then RD1=WD3. The same rule applies to RD2 with A2. This gives zero-cycle read-after-write.
  - With BYPASS=0, reads return the stored value; a write is visible the cycle after its edge.
- Scoreboard: one pending bit per register, updated on the CLK edge with this priority:
  1. CLR_ALL: all bits are cleared; any SET_EN or WE3 in the same cycle has no scoreboard effect. The data write still occurs.
  2. SET_EN with a valid SET_A: busy[SET_A] <= 1.
  3. WE3 with a valid A3: busy[A3] <= 0, unless A3==SET_A with SET_EN high, in which case set wins (a new writer was issued after the old one retired).
  - With ZERO_REG=1, SET_A==0 is ignored, so register 0 is never busy.
- BUSYn output:
  - BUSYn = busy[An], or 0 for an invalid address.
  - With BYPASS=1, BUSYn is forced to 0 when WE3 is high, A3 is valid and A3==An.
- PEND_CNT: a registered count equal to the population count of the pending bits, updated incrementally.
  - +1 only on a 0->1 transition of a pending bit.
  - -1 only on a 1->0 transition.
  - Set and clear of different registers in the same cycle: net 0.
  - Setting an already-busy register or clearing a non-busy register: no change.
  - CLR_ALL: count goes to 0.
  - The count never exceeds NUM_REGS - ZERO_REG and never underflows.

Decomposition:
- Package reg_file_pkg holds:
  - default DATA_W and ADDR_W constants;
  - the ZERO_ADDR constant;
  - a function addr_valid(addr, NUM_REGS, ZERO_REG).
- Sub-module rf_scoreboard contains the pending-bit vector, the priority logic, PEND_CNT and the BUSY lookup with bypass masking. The top level contains the data array, the write logic and the read muxes.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse RST between clock edges. RD1 with A1=5 reads 0 before the next edge, and PEND_CNT=0.
- Zero register: WE3=1, A3=0, WD3=0x1234, and SET_EN=1, SET_A=0. After the edge, RD1 with A1=0 reads 0, BUSY1=0 and PEND_CNT=0. Repeat with ZERO_REG=0: RD1 reads 0x1234.
- Bypass: with BYPASS=1, in the same cycle drive WE3=1, A3=7, WD3=0xA5A5A5A5 and A1=A2=7. RD1=RD2=0xA5A5A5A5 before the edge. With BYPASS=0, the old value is read until after the edge.
- Scoreboard lifecycle:
  - Set r3 and then r9 in successive cycles: PEND_CNT goes 1 then 2.
  - Set r3 again: count stays 2.
  - Write r3: BUSY for r3 drops (same cycle with BYPASS=1) and PEND_CNT=1.
- Simultaneous events, starting from r9 busy and PEND_CNT=1:
  - SET_EN=1 with SET_A=4, and WE3=1 with A3=4: r4 stays busy; PEND_CNT goes 1 -> 2.
  - Next cycle, CLR_ALL=1 together with SET_EN=1, SET_A=12: all BUSY=0 and PEND_CNT=0.
- Out-of-range, with NUM_REGS=24: a write to A3=30 is ignored, a read from A1=30 returns 0, and SET_A=30 leaves PEND_CNT unchanged.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and address-validity helper for the register file.
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    // An address is usable when it names an implemented register that is not
    // the hardwired zero register.
    function automatic logic addr_valid(input int unsigned addr,
                                        input int          num_regs,
                                        input int          zero_reg);
        return (addr < num_regs) && !((zero_reg != 0) && (addr == ZERO_ADDR));
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, a running pending
// count and the BUSY lookups for both read ports.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic              SET_EN,
    input  logic [ADDR_W-1:0] SET_A,
    input  logic              CLR_ALL,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic              BUSY1,
    output logic              BUSY2,
    output logic [ADDR_W:0]   PEND_CNT
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [NUM_REGS-1:0] busy;
    logic [DEPTH-1:0]    busy_ext;
    logic [DEPTH-1:0]    busy_nxt_ext;
    logic [ADDR_W:0]     cnt_nxt;
    logic                set_ok;
    logic                wr_ok;
    logic                set_wins;
    logic                inc;
    logic                dec;

    // Unimplemented addresses see a permanently clear bit.
    assign busy_ext = DEPTH'(busy);
    assign set_ok   = SET_EN && addr_valid(32'(SET_A), NUM_REGS, ZERO_REG);
    assign wr_ok    = WE3 && addr_valid(32'(A3), NUM_REGS, ZERO_REG);
    assign set_wins = set_ok && (SET_A == A3);
    assign inc      = set_ok && !busy_ext[SET_A];
    assign dec      = wr_ok && busy_ext[A3] && !set_wins;

    // Next pending vector and count: flush beats set, set beats retire.
    always_comb begin
        busy_nxt_ext = busy_ext;
        cnt_nxt      = PEND_CNT;
        if (CLR_ALL) begin
            busy_nxt_ext = '0;
            cnt_nxt      = '0;
        end else begin
            if (wr_ok && !set_wins) busy_nxt_ext[A3] = 1'b0;
            if (set_ok)             busy_nxt_ext[SET_A] = 1'b1;
            if (inc && !dec)        cnt_nxt = PEND_CNT + (ADDR_W+1)'(1);
            else if (dec && !inc)   cnt_nxt = PEND_CNT - (ADDR_W+1)'(1);
        end
    end

    // Pending state register with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy     <= '0;
            PEND_CNT <= '0;
        end else begin
            busy     <= busy_nxt_ext[NUM_REGS-1:0];
            PEND_CNT <= cnt_nxt;
        end
    end

    // A retiring write to the same register hides its busy bit this cycle.
    always_comb begin
        BUSY1 = busy_ext[A1] && addr_valid(32'(A1), NUM_REGS, ZERO_REG);
        BUSY2 = busy_ext[A2] && addr_valid(32'(A2), NUM_REGS, ZERO_REG);
        if ((BYPASS != 0) && wr_ok && (A3 == A1)) BUSY1 = 1'b0;
        if ((BYPASS != 0) && wr_ok && (A3 == A2)) BUSY2 = 1'b0;
    end

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with optional zero register, write bypass
// and a pending-write scoreboard for the stall unit.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              SET_EN,
    input  logic [ADDR_W-1:0] SET_A,
    input  logic              CLR_ALL,
    output logic              BUSY1,
    output logic              BUSY2,
    output logic [ADDR_W:0]   PEND_CNT
);

    logic [DATA_W-1:0] rf [NUM_REGS];
    logic              wr_ok;

    assign wr_ok = WE3 && addr_valid(32'(A3), NUM_REGS, ZERO_REG);

    // Data array: cleared asynchronously, written at writeback.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wr_ok) begin
            rf[A3] <= WD3;
        end
    end

    // Read port 1: forwarded write data first, then stored value, else zero.
    always_comb begin
        RD1 = '0;
        if ((BYPASS != 0) && wr_ok && (A3 == A1))            RD1 = WD3;
        else if (addr_valid(32'(A1), NUM_REGS, ZERO_REG))    RD1 = rf[A1];
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        RD2 = '0;
        if ((BYPASS != 0) && wr_ok && (A3 == A2))            RD2 = WD3;
        else if (addr_valid(32'(A2), NUM_REGS, ZERO_REG))    RD2 = rf[A2];
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .CLK      (CLK),
        .RST      (RST),
        .WE3      (WE3),
        .A3       (A3),
        .SET_EN   (SET_EN),
        .SET_A    (SET_A),
        .CLR_ALL  (CLR_ALL),
        .A1       (A1),
        .A2       (A2),
        .BUSY1    (BUSY1),
        .BUSY2    (BUSY2),
        .PEND_CNT (PEND_CNT)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two configurations share one stimulus stream and
// are compared every cycle against an array-based reference model.
module tb_reg_file_sb;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  a1 = '0, a2 = '0, a3 = '0, set_a = '0;
    logic [31:0] wd = '0;
    logic        set_en = 1'b0, clr = 1'b0;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        b1_a, b2_a, b1_b, b2_b;
    logic [5:0]  cnt_a, cnt_b;

    int n_checks = 0;
    int n_err    = 0;

    // Instance 0: 32 regs, zero reg, bypass.  Instance 1: 24 regs, neither.
    int nregs [2] = '{32, 24};
    int zr    [2] = '{1, 0};
    int byp   [2] = '{1, 0};

    logic [31:0] mrf [2][32];
    bit          mb  [2][32];

    always #5 clk_sys = ~clk_sys;

    reg_file_sb #(.NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) u_a (
        .CLK(clk_sys), .RST(rst), .WE3(we), .A1(a1), .A2(a2), .A3(a3), .WD3(wd),
        .RD1(rd1_a), .RD2(rd2_a), .SET_EN(set_en), .SET_A(set_a), .CLR_ALL(clr),
        .BUSY1(b1_a), .BUSY2(b2_a), .PEND_CNT(cnt_a));

    reg_file_sb #(.NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) u_b (
        .CLK(clk_sys), .RST(rst), .WE3(we), .A1(a1), .A2(a2), .A3(a3), .WD3(wd),
        .RD1(rd1_b), .RD2(rd2_b), .SET_EN(set_en), .SET_A(set_a), .CLR_ALL(clr),
        .BUSY1(b1_b), .BUSY2(b2_b), .PEND_CNT(cnt_b));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_valid(input int k, input int a);
        return (a < nregs[k]) && !(zr[k] != 0 && a == 0);
    endfunction

    function automatic bit m_fwd(input int k, input int a);
        return byp[k] != 0 && we && m_valid(k, int'(a3)) && int'(a3) == a;
    endfunction

    function automatic logic [31:0] m_read(input int k, input int a);
        if (m_fwd(k, a))   return wd;
        if (m_valid(k, a)) return mrf[k][a];
        return 32'd0;
    endfunction

    function automatic bit m_busy(input int k, input int a);
        if (!m_valid(k, a) || m_fwd(k, a)) return 1'b0;
        return mb[k][a];
    endfunction

    function automatic int m_cnt(input int k);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mb[k][i]);
        return c;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                mrf[k][i] = '0;
                mb[k][i]  = 1'b0;
            end
    endtask

    // Edge behaviour: data write, then scoreboard with flush > set > retire.
    task automatic m_step();
        if (rst) begin
            m_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (we && m_valid(k, int'(a3))) mrf[k][a3] = wd;
            if (clr) begin
                for (int i = 0; i < 32; i++) mb[k][i] = 1'b0;
            end else begin
                if (we && m_valid(k, int'(a3)))        mb[k][a3] = 1'b0;
                if (set_en && m_valid(k, int'(set_a))) mb[k][set_a] = 1'b1;
            end
        end
    endtask

    task automatic cmp_inst(input int k, input logic [31:0] r1, input logic [31:0] r2,
                            input logic bz1, input logic bz2, input logic [5:0] c);
        check($sformatf("rd1_i%0d_a%0d", k, a1), 64'(r1), 64'(m_read(k, int'(a1))));
        check($sformatf("rd2_i%0d_a%0d", k, a2), 64'(r2), 64'(m_read(k, int'(a2))));
        check($sformatf("busy1_i%0d_a%0d", k, a1), 64'(bz1), 64'(m_busy(k, int'(a1))));
        check($sformatf("busy2_i%0d_a%0d", k, a2), 64'(bz2), 64'(m_busy(k, int'(a2))));
        check($sformatf("pend_cnt_i%0d", k), 64'(c), 64'(m_cnt(k)));
    endtask

    // Apply one cycle of inputs, compare before the edge, advance the model.
    task automatic cycle(input logic i_we, input logic [4:0] i_a3, input logic [31:0] i_wd,
                         input logic [4:0] i_a1, input logic [4:0] i_a2,
                         input logic i_set, input logic [4:0] i_sa,
                         input logic i_clr, input logic i_rst);
        we = i_we; a3 = i_a3; wd = i_wd; a1 = i_a1; a2 = i_a2;
        set_en = i_set; set_a = i_sa; clr = i_clr; rst = i_rst;
        @(negedge clk_sys);
        if (!rst) begin
            cmp_inst(0, rd1_a, rd2_a, b1_a, b2_a, cnt_a);
            cmp_inst(1, rd1_b, rd2_b, b1_b, b2_b, cnt_b);
        end
        @(posedge clk_sys);
        m_step();
        #1;
    endtask

    initial begin
        m_reset();
        #1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset pulsed between edges clears storage immediately.
        cycle(1, 5, 32'hDEADBEEF, 5, 5, 1, 5, 0, 0);
        we = 0; set_en = 0; a1 = 5;
        #1;
        check("pre_rst_rd1", 64'(rd1_a), 64'h0000_0000_DEAD_BEEF);
        rst = 1;
        #1;
        check("rst_rd1_a", 64'(rd1_a), 64'd0);
        check("rst_rd1_b", 64'(rd1_b), 64'd0);
        check("rst_pend_a", 64'(cnt_a), 64'd0);
        m_reset();
        rst = 0;
        @(posedge clk_sys);
        #1;

        // Zero register: write and set to r0.
        cycle(1, 0, 32'h1234, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("zero_rd1_a", 64'(rd1_a), 64'd0);
        check("nozero_rd1_b", 64'(rd1_b), 64'h1234);

        // Bypass: same-cycle write forwarded only on instance 0.
        we = 1; a3 = 7; wd = 32'hA5A5A5A5; a1 = 7; a2 = 7;
        #1;
        check("byp_rd1_a", 64'(rd1_a), 64'hA5A5A5A5);
        check("byp_rd2_a", 64'(rd2_a), 64'hA5A5A5A5);
        check("nobyp_rd1_b", 64'(rd1_b), 64'd0);
        cycle(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0, 0);
        cycle(0, 0, 0, 7, 7, 0, 0, 0, 0);

        // Scoreboard lifecycle.
        cycle(0, 0, 0, 3, 9, 1, 3, 0, 0);
        cycle(0, 0, 0, 3, 9, 1, 9, 0, 0);
        check("cnt_after_2set", 64'(cnt_a), 64'd2);
        cycle(0, 0, 0, 3, 9, 1, 3, 0, 0);
        cycle(1, 3, 32'h33, 3, 9, 0, 0, 0, 0);
        check("cnt_after_wr3", 64'(cnt_a), 64'd1);

        // Simultaneous set and retire of r4, then flush with a set.
        cycle(1, 4, 32'h44, 4, 9, 1, 4, 0, 0);
        check("cnt_set_wins", 64'(cnt_a), 64'd2);
        cycle(0, 0, 0, 4, 12, 1, 12, 1, 0);
        cycle(0, 0, 0, 4, 12, 0, 0, 0, 0);
        check("cnt_after_flush", 64'(cnt_b), 64'd0);

        // Out of range for the 24-entry instance.
        cycle(1, 30, 32'hBAD, 30, 30, 1, 30, 0, 0);
        cycle(0, 0, 0, 30, 30, 0, 0, 0, 0);
        check("oor_rd1_b", 64'(rd1_b), 64'd0);
        check("oor_cnt_b", 64'(cnt_b), 64'd0);

        // Randomized traffic, addresses biased to a small window for hits.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] r_a1, r_a2, r_a3, r_sa;
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            r_a1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r_a2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r_a3 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r_sa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), r_a3, $urandom, r_a1, r_a2,
                  1'($urandom_range(0, 1)), r_sa,
                  ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
